// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing the unified instruction/data memory between the CPU and an IO/loader port.
// Define MEMARB_IO_PRIORITY_EN for fixed IO-wins-ties priority; leave it undefined for round-robin.
module mem_arbiter #(
   parameter int AW      = 16,
   parameter int DW      = 16,
   parameter int MEM_LAT = 2
) (
   input  logic          CLK,
   input  logic          Reset,

   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_done,
   output logic          cpu_stall,

   input  logic          io_req,
   input  logic          io_we,
   input  logic [AW-1:0] io_addr,
   input  logic [DW-1:0] io_wdata,
   output logic          io_gnt,
   output logic          io_done,

   output logic [DW-1:0] rdata,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_we,
   output logic          mem_re,
   input  logic [DW-1:0] mem_rdata
);

   localparam int CW = $clog2(MEM_LAT + 1);
   localparam logic [CW-1:0] CNT_START = CW'(MEM_LAT - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_IO  = 1'b1
   } owner_t;

   state_t          state_q;
   owner_t          owner_q;
   owner_t          last_q;
   logic [CW-1:0]   cnt_q;
   logic [AW-1:0]   memAddr_q;
   logic [DW-1:0]   memWdata_q;
   logic            we_q;
   logic [DW-1:0]   rdata_q;
   logic            cpuGnt_q;
   logic            ioGnt_q;
   logic            cpuDone_q;
   logic            ioDone_q;
   logic            memWe_q;
   logic            memRe_q;

   logic            cpuCand;
   logic            ioCand;
   logic            grantValid;
   owner_t          owner_d;
   logic [AW-1:0]   addr_d;
   logic [DW-1:0]   wdata_d;
   logic            we_d;

   // The port being completed in DONE is excluded so it cannot chain straight back in.
   always_comb begin
      cpuCand    = cpu_req & ~((state_q == DONE) && (owner_q == OWN_CPU));
      ioCand     = io_req  & ~((state_q == DONE) && (owner_q == OWN_IO));
      grantValid = ((state_q == IDLE) || (state_q == DONE)) && (cpuCand || ioCand);
`ifdef MEMARB_IO_PRIORITY_EN
      owner_d    = ioCand ? OWN_IO : OWN_CPU;
`else
      owner_d    = (ioCand && (!cpuCand || (last_q == OWN_CPU))) ? OWN_IO : OWN_CPU;
`endif
      addr_d     = (owner_d == OWN_IO) ? io_addr  : cpu_addr;
      wdata_d    = (owner_d == OWN_IO) ? io_wdata : cpu_wdata;
      we_d       = (owner_d == OWN_IO) ? io_we    : cpu_we;
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_q    <= IDLE;
         owner_q    <= OWN_CPU;
         last_q     <= OWN_IO;
         cnt_q      <= '0;
         memAddr_q  <= '0;
         memWdata_q <= '0;
         we_q       <= 1'b0;
         rdata_q    <= '0;
         cpuGnt_q   <= 1'b0;
         ioGnt_q    <= 1'b0;
         cpuDone_q  <= 1'b0;
         ioDone_q   <= 1'b0;
         memWe_q    <= 1'b0;
         memRe_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               cpuDone_q <= 1'b0;
               ioDone_q  <= 1'b0;
               if (grantValid) begin
                  state_q    <= ACCESS;
                  owner_q    <= owner_d;
                  last_q     <= owner_d;
                  cnt_q      <= CNT_START;
                  memAddr_q  <= addr_d;
                  memWdata_q <= wdata_d;
                  we_q       <= we_d;
                  cpuGnt_q   <= (owner_d == OWN_CPU);
                  ioGnt_q    <= (owner_d == OWN_IO);
                  memWe_q    <= we_d;
                  memRe_q    <= ~we_d;
               end else begin
                  state_q  <= IDLE;
                  cpuGnt_q <= 1'b0;
                  ioGnt_q  <= 1'b0;
                  memWe_q  <= 1'b0;
                  memRe_q  <= 1'b0;
               end
            end

            ACCESS: begin
               // The write strobe only ever covers the first ACCESS cycle.
               memWe_q <= 1'b0;
               if (cnt_q == '0) begin
                  state_q   <= DONE;
                  memRe_q   <= 1'b0;
                  cpuDone_q <= (owner_q == OWN_CPU);
                  ioDone_q  <= (owner_q == OWN_IO);
                  if (!we_q) begin
                     rdata_q <= mem_rdata;
                  end
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end

            default: begin
               state_q  <= IDLE;
               cpuGnt_q <= 1'b0;
               ioGnt_q  <= 1'b0;
               memWe_q  <= 1'b0;
               memRe_q  <= 1'b0;
            end
         endcase
      end
   end

   assign cpu_gnt   = cpuGnt_q;
   assign io_gnt    = ioGnt_q;
   assign cpu_done  = cpuDone_q;
   assign io_done   = ioDone_q;
   assign cpu_stall = cpu_req & ~cpuDone_q;
   assign rdata     = rdata_q;
   assign mem_addr  = memAddr_q;
   assign mem_wdata = memWdata_q;
   assign mem_we    = memWe_q;
   assign mem_re    = memRe_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter (default round-robin build, MEM_LAT=2).
module tb_mem_arbiter;

   logic        CLK;
   logic        Reset;
   logic        cpu_req;
   logic        cpu_we;
   logic [15:0] cpu_addr;
   logic [15:0] cpu_wdata;
   logic        cpu_gnt;
   logic        cpu_done;
   logic        cpu_stall;
   logic        io_req;
   logic        io_we;
   logic [15:0] io_addr;
   logic [15:0] io_wdata;
   logic        io_gnt;
   logic        io_done;
   logic [15:0] rdata;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_we;
   logic        mem_re;
   logic [15:0] mem_rdata;

   logic [15:0] memArr [0:255];

   int checkCount;
   int failCount;

   mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(2)) dut (
      .CLK       (CLK),
      .Reset     (Reset),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_gnt   (cpu_gnt),
      .cpu_done  (cpu_done),
      .cpu_stall (cpu_stall),
      .io_req    (io_req),
      .io_we     (io_we),
      .io_addr   (io_addr),
      .io_wdata  (io_wdata),
      .io_gnt    (io_gnt),
      .io_done   (io_done),
      .rdata     (rdata),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_re    (mem_re),
      .mem_rdata (mem_rdata)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Memory model: location 0x0004 holds 0x1234 after reset; read data only while mem_re.
   always @(posedge CLK) begin
      if (Reset)
         memArr[8'h04] <= 16'h1234;
      else if (mem_we)
         memArr[mem_addr[7:0]] <= mem_wdata;
   end

   assign mem_rdata = mem_re ? memArr[mem_addr[7:0]] : 16'h0000;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic cReq, input logic cWe, input logic [15:0] cAddr,
                                input logic [15:0] cWdata, input logic iReq, input logic iWe,
                                input logic [15:0] iAddr, input logic [15:0] iWdata);
      cpu_req   = cReq;
      cpu_we    = cWe;
      cpu_addr  = cAddr;
      cpu_wdata = cWdata;
      io_req    = iReq;
      io_we     = iWe;
      io_addr   = iAddr;
      io_wdata  = iWdata;
   endtask

   task automatic waitCycles(input int n);
      for (int i = 0; i < n; i++) @(negedge CLK);
   endtask

   function automatic logic [3:0] handshake();
      return {cpu_gnt, io_gnt, cpu_done, io_done};
   endfunction

   // Expected {cpu_gnt, io_gnt, cpu_done, io_done} with both ports requesting reads continuously.
   logic [3:0] rrExpect [0:8];

   initial begin
      checkCount = 0;
      failCount  = 0;
      rrExpect[0] = 4'b1000; rrExpect[1] = 4'b1000; rrExpect[2] = 4'b1010;
      rrExpect[3] = 4'b0100; rrExpect[4] = 4'b0100; rrExpect[5] = 4'b0101;
      rrExpect[6] = 4'b1000; rrExpect[7] = 4'b1000; rrExpect[8] = 4'b1010;

      // Reset values
      Reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
      #1;
      checkOutput("rst_handshake", {28'h0, handshake()}, 32'h0);
      checkOutput("rst_mem_strobes", {30'h0, mem_we, mem_re}, 32'h0);
      checkOutput("rst_mem_addr", {16'h0, mem_addr}, 32'h0);
      checkOutput("rst_mem_wdata", {16'h0, mem_wdata}, 32'h0);
      checkOutput("rst_rdata", {16'h0, rdata}, 32'h0);
      cpu_req = 1'b1;
      #1;
      checkOutput("rst_stall_follows_req", {31'h0, cpu_stall}, 32'h1);
      cpu_req = 1'b0;
      waitCycles(2);
      Reset = 1'b0;
      waitCycles(1);

      // CPU read of 0x0004
      applyStimulus(1'b1, 1'b0, 16'h0004, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
      waitCycles(1);
      checkOutput("rd_acc1_handshake", {28'h0, handshake()}, 32'h8);
      checkOutput("rd_acc1_mem_re", {31'h0, mem_re}, 32'h1);
      checkOutput("rd_acc1_mem_addr", {16'h0, mem_addr}, 32'h0004);
      checkOutput("rd_acc1_stall", {31'h0, cpu_stall}, 32'h1);
      waitCycles(1);
      checkOutput("rd_acc2_handshake", {28'h0, handshake()}, 32'h8);
      checkOutput("rd_acc2_mem_re", {31'h0, mem_re}, 32'h1);
      waitCycles(1);
      checkOutput("rd_done_handshake", {28'h0, handshake()}, 32'hA);
      checkOutput("rd_done_rdata", {16'h0, rdata}, 32'h1234);
      checkOutput("rd_done_stall", {31'h0, cpu_stall}, 32'h0);
      checkOutput("rd_done_mem_re", {31'h0, mem_re}, 32'h0);
      cpu_req = 1'b0;
      waitCycles(1);
      checkOutput("rd_idle_handshake", {28'h0, handshake()}, 32'h0);
      checkOutput("rd_idle_rdata_hold", {16'h0, rdata}, 32'h1234);

      // IO write of 0xBEEF to 0x0010
      applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
      waitCycles(1);
      checkOutput("wr_acc1_handshake", {28'h0, handshake()}, 32'h4);
      checkOutput("wr_acc1_strobes", {30'h0, mem_we, mem_re}, 32'h2);
      checkOutput("wr_acc1_mem_wdata", {16'h0, mem_wdata}, 32'hBEEF);
      checkOutput("wr_acc1_mem_addr", {16'h0, mem_addr}, 32'h0010);
      waitCycles(1);
      checkOutput("wr_acc2_handshake", {28'h0, handshake()}, 32'h4);
      checkOutput("wr_acc2_strobes", {30'h0, mem_we, mem_re}, 32'h0);
      waitCycles(1);
      checkOutput("wr_done_handshake", {28'h0, handshake()}, 32'h5);
      checkOutput("wr_done_rdata_hold", {16'h0, rdata}, 32'h1234);
      io_req = 1'b0;
      waitCycles(1);

      // CPU read back of 0x0010
      applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
      waitCycles(3);
      checkOutput("rb_done_handshake", {28'h0, handshake()}, 32'hA);
      checkOutput("rb_rdata", {16'h0, rdata}, 32'hBEEF);
      cpu_req = 1'b0;
      waitCycles(1);

      // Both requesting continuously from reset: CPU wins the first tie, then strict alternation
      Reset = 1'b1;
      waitCycles(1);
      Reset = 1'b0;
      waitCycles(1);
      applyStimulus(1'b1, 1'b0, 16'h0004, 16'h0, 1'b1, 1'b0, 16'h0010, 16'h0);
      for (int c = 0; c < 9; c++) begin
         waitCycles(1);
         checkOutput($sformatf("rr_cycle%0d", c + 1), {28'h0, handshake()}, {28'h0, rrExpect[c]});
         if (c == 5) checkOutput("rr_io_rdata", {16'h0, rdata}, 32'hBEEF);
         if (c == 8) checkOutput("rr_cpu_rdata", {16'h0, rdata}, 32'h1234);
      end
      applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
      waitCycles(1);
      checkOutput("rr_idle_handshake", {28'h0, handshake()}, 32'h0);

      // CPU drops its request mid-ACCESS: the access still completes once
      applyStimulus(1'b1, 1'b0, 16'h0004, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
      waitCycles(1);
      cpu_req = 1'b0;
      #1;
      checkOutput("drop_stall_low", {31'h0, cpu_stall}, 32'h0);
      waitCycles(1);
      checkOutput("drop_acc2_handshake", {28'h0, handshake()}, 32'h8);
      waitCycles(1);
      checkOutput("drop_done_handshake", {28'h0, handshake()}, 32'hA);
      checkOutput("drop_done_rdata", {16'h0, rdata}, 32'h1234);
      waitCycles(1);
      checkOutput("drop_idle1_handshake", {28'h0, handshake()}, 32'h0);
      waitCycles(1);
      checkOutput("drop_idle2_handshake", {28'h0, handshake()}, 32'h0);

      // Reset in the first ACCESS cycle of a CPU write
      applyStimulus(1'b1, 1'b1, 16'h0020, 16'h5555, 1'b0, 1'b0, 16'h0, 16'h0);
      waitCycles(1);
      checkOutput("rstacc_pre_strobes", {30'h0, mem_we, mem_re}, 32'h2);
      Reset = 1'b1;
      #1;
      checkOutput("rstacc_handshake", {28'h0, handshake()}, 32'h0);
      checkOutput("rstacc_strobes", {30'h0, mem_we, mem_re}, 32'h0);
      checkOutput("rstacc_mem_addr", {16'h0, mem_addr}, 32'h0);
      checkOutput("rstacc_mem_wdata", {16'h0, mem_wdata}, 32'h0);
      checkOutput("rstacc_rdata", {16'h0, rdata}, 32'h0);
      waitCycles(1);
      checkOutput("rstacc_held_handshake", {28'h0, handshake()}, 32'h0);
      Reset = 1'b0;
      waitCycles(1);
      checkOutput("rstacc_new_acc1", {28'h0, handshake()}, 32'h8);
      checkOutput("rstacc_new_we", {30'h0, mem_we, mem_re}, 32'h2);
      waitCycles(1);
      checkOutput("rstacc_new_acc2", {28'h0, handshake()}, 32'h8);
      waitCycles(1);
      checkOutput("rstacc_new_done", {28'h0, handshake()}, 32'hA);
      cpu_req = 1'b0;
      waitCycles(1);
      checkOutput("rstacc_final_idle", {28'h0, handshake()}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
